// File: rtl/pkt_pkg.sv
// Shared packet definitions for the PU crossbar: field positions, packet/PU-id types, arbiter helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Packet layout: [PKTW] valid, [PKTW-1:PKTW-2] destination PU, [PKTW-3:0] payload.
`ifndef PKTW
`define PKTW 16
`endif

package pkt_pkg;

  localparam int PKTW      = `PKTW;
  localparam int NPU       = 4;
  localparam int VALID_BIT = PKTW;
  localparam int DEST_MSB  = PKTW - 1;
  localparam int DEST_LSB  = PKTW - 2;

  typedef logic [`PKTW:0] pkt_t;
  typedef logic [1:0]     pu_id_t;

  // One arbiter decision: whether anything was granted, and to which source.
  typedef struct packed {
    logic   vld;
    pu_id_t src;
  } grant_t;

  function automatic pu_id_t pkt_dest(input pkt_t p);
    return p[DEST_MSB:DEST_LSB];
  endfunction

  // Round-robin pick: first requester at or after 'start', wrapping.
  // Walking from the far end lets the nearest requester overwrite earlier picks.
  function automatic grant_t rr_pick(input logic [NPU-1:0] req, input pu_id_t start);
    grant_t g;
    pu_id_t s;
    g = '0;
    for (int k = NPU - 1; k >= 0; k--) begin
      s = start + pu_id_t'(k);
      if (req[s]) begin
        g.vld = 1'b1;
        g.src = s;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Small synchronous packet FIFO, one per crossbar source.
// Latency: a pushed entry is visible on head_dat the cycle after the push edge.
// Backpressure: none upstream; push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk, rst (async active-low), push/push_dat (enqueue), pop (dequeue head),
//        head_dat (oldest entry, valid when !empty), full, empty.
module pkt_fifo
  import pkt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  pkt_t push_dat,
  input  logic pop,
  output pkt_t head_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  pkt_t        mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed through non-empty pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/pkt_xbar.sv
// 4x4 packet crossbar: per-source input FIFOs, per-destination round-robin arbiters, registered rx outputs.
// Latency: 2 cycles from tx_in to rx_out with an empty FIFO and no contention.
// Backpressure: none; a packet arriving at a full FIFO (with no pop that cycle) is dropped and counted.
//
// Ports: clk, rst (async active-low), tx_in[i] (packet from PU i), rx_out[j] (packet to PU j,
//        valid one cycle), drop_cnt[i] (saturating drops at source i), busy (any FIFO non-empty).
module pkt_xbar
  import pkt_pkg::*;
#(
  parameter int FDEPTH = 4,
  parameter int CNTW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  pkt_t [NPU-1:0]            tx_in,
  output pkt_t [NPU-1:0]            rx_out,
  output logic [NPU-1:0][CNTW-1:0]  drop_cnt,
  output logic                      busy
);

  logic [NPU-1:0]          fifo_full;
  logic [NPU-1:0]          fifo_empty;
  logic [NPU-1:0]          fifo_push;
  logic [NPU-1:0]          fifo_pop;
  logic [NPU-1:0]          drop_vld;
  pkt_t [NPU-1:0]          head_dat;
  logic [NPU-1:0][NPU-1:0] req;       // req[dest][src]
  grant_t [NPU-1:0]        gnt;       // gnt[dest]
  pu_id_t [NPU-1:0]        rr;        // rr[dest]: first source considered next

  for (genvar s = 0; s < NPU; s++) begin : g_src
    pkt_fifo #(.DEPTH(FDEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push[s]),
      .push_dat (tx_in[s]),
      .pop      (fifo_pop[s]),
      .head_dat (head_dat[s]),
      .full     (fifo_full[s]),
      .empty    (fifo_empty[s])
    );
  end

  // Only the head of each queue requests, which gives strict per-source ordering.
  always_comb begin
    req = '0;
    for (int s = 0; s < NPU; s++) begin
      if (!fifo_empty[s]) req[pkt_dest(head_dat[s])][s] = 1'b1;
    end
  end

  always_comb begin
    gnt = '0;
    for (int j = 0; j < NPU; j++) gnt[j] = rr_pick(req[j], rr[j]);
  end

  // A source requests one destination at most, so at most one grant pops it.
  always_comb begin
    fifo_pop = '0;
    for (int j = 0; j < NPU; j++) begin
      if (gnt[j].vld) fifo_pop[gnt[j].src] = 1'b1;
    end
  end

  // A same-cycle pop frees a slot, so the push goes through instead of dropping.
  always_comb begin
    fifo_push = '0;
    drop_vld  = '0;
    for (int s = 0; s < NPU; s++) begin
      fifo_push[s] = tx_in[s][VALID_BIT] && (!fifo_full[s] || fifo_pop[s]);
      drop_vld[s]  = tx_in[s][VALID_BIT] && fifo_full[s] && !fifo_pop[s];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_out   <= '0;
      rr       <= '0;
      drop_cnt <= '0;
    end else begin
      for (int j = 0; j < NPU; j++) begin
        rx_out[j] <= gnt[j].vld ? head_dat[gnt[j].src] : '0;
        if (gnt[j].vld) rr[j] <= gnt[j].src + pu_id_t'(1);
      end
      for (int s = 0; s < NPU; s++) begin
        if (drop_vld[s] && (drop_cnt[s] != '1)) drop_cnt[s] <= drop_cnt[s] + CNTW'(1);
      end
    end
  end

  assign busy = ~&fifo_empty;

endmodule
